mem_access_stage: RTL and testbench

Memory-access stage of the pipelined MIPS core, directly downstream of the ALU. It consumes the EX-stage ALU result as an effective address (or as pass-through data), drives a single-outstanding-request data-memory port, and formats load and store data. It also registers the MEM/WB payload for writeback. It stalls EX while a memory transaction is in flight.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 tb/tb_mem_access_stage.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared op/state types and op-class helpers for the memory-access stage
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_e;

  // Encodings 9..15 fall outside both ranges and therefore act as NONE.
  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - single-outstanding data-memory port
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - combinational lane select and sign/zero extension of load data
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [3:0]  op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (mem_op_e'(op))
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'd0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: dmem request FSM, store/load formatting, MEM/WB register
// Optional alignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  input  logic [3:0]        mem_op,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  mem_access_stage_if.master dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_exc
);

  mem_state_e  state_q, state_d;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic        rw_q;

  logic        accept, is_mem, misalign, start_mem;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mem    = is_load(mem_op) || is_store(mem_op);
  assign start_mem = accept && is_mem && !misalign;

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (mem_op_e'(mem_op))
      MEM_LH, MEM_LHU, MEM_SH: misalign = alu_res[0];
      MEM_LW, MEM_SW:          misalign = |alu_res[1:0];
      default:                 misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (mem_op_e'(mem_op))
      MEM_SB: begin
        be_d    = 4'b0001 << alu_res[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      MEM_SH: begin
        be_d    = alu_res[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mem) state_d = REQ;
      REQ:     if (dmem.dmem_gnt) state_d = is_store(op_q) ? IDLE : WAIT_R;
      WAIT_R:  if (dmem.dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are registered at acceptance so they hold still until grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      op_q            <= '0;
      lane_q          <= '0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
    end else if (state_q == IDLE && start_mem) begin
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= is_store(mem_op);
      dmem.dmem_addr  <= {alu_res[31:2], 2'b00};
      dmem.dmem_be    <= be_d;
      dmem.dmem_wdata <= wdata_d;
      op_q            <= mem_op;
      lane_q          <= alu_res[1:0];
      rd_q            <= rd;
      rw_q            <= reg_write;
    end else if (state_q == REQ && dmem.dmem_gnt) begin
      dmem.dmem_req   <= 1'b0;
    end
  end

  mem_load_align u_load_align (
    .rdata (dmem.dmem_rdata),
    .lane  (lane_q),
    .op    (op_q),
    .data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      misalign_exc <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_exc <= 1'b0;
      case (state_q)
        IDLE: if (accept && !start_mem) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd;
          wb_reg_write <= reg_write && !misalign;
          wb_data      <= alu_res;
          misalign_exc <= misalign;
        end
        REQ: if (dmem.dmem_gnt && is_store(op_q)) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd_q;
          wb_reg_write <= 1'b0;
          wb_data      <= dmem.dmem_addr;
        end
        WAIT_R: if (dmem.dmem_rvalid) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd_q;
          wb_reg_write <= rw_q;
          wb_data      <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench with randomized payloads and a memory responder model
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd;
  logic        reg_write;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_exc;

  mem_access_stage_if dmem_bus ();

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_res      (alu_res),
    .store_data   (store_data),
    .mem_op       (mem_op),
    .rd           (rd),
    .reg_write    (reg_write),
    .dmem         (dmem_bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    bit          chk_data;
    logic        exc;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          hold;
    int          rv_delay;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] load_model(input int op, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] b, h;
    logic [1:0]  lane;
    lane = a[1:0];
    b = (rdata >> (8 * lane)) & 32'h0000_00ff;
    h = (rdata >> (16 * lane[1])) & 32'h0000_ffff;
    case (op)
      1:       return b[7] ? (b | 32'hffff_ff00) : b;
      2:       return b;
      3:       return h[15] ? (h | 32'hffff_0000) : h;
      4:       return h;
      default: return rdata;
    endcase
  endfunction

  function automatic bit model_misalign(input int op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    logic [1:0] lo;
    lo = a[1:0];
    return ((op == 3 || op == 4 || op == 7) && lo[0]) || ((op == 5 || op == 8) && lo != 2'b00);
`else
    return (op < 0) && (a == 32'd0);
`endif
  endfunction

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                       input logic w, input logic [31:0] rdata, input int hold, input int rv_delay,
                       output int acc_cyc);
    int       guard;
    bit       ld, st, mis;
    req_exp_t rq;
    wb_exp_t  we;
    logic [7:0]  sb;
    logic [15:0] sh;
    @(negedge clk);
    in_valid   = 1'b1;
    alu_res    = a;
    store_data = sd;
    mem_op     = op[3:0];
    rd         = r;
    reg_write  = w;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    acc_cyc = cyc;
    ld  = (op >= 1 && op <= 5);
    st  = (op >= 6 && op <= 8);
    mis = model_misalign(op, a);
    if ((ld || st) && !mis) begin
      sb = sd[7:0];
      sh = sd[15:0];
      rq.we       = st;
      rq.addr     = a & 32'hffff_fffc;
      rq.rdata    = rdata;
      rq.hold     = hold;
      rq.rv_delay = rv_delay;
      rq.be       = 4'hf;
      rq.wdata    = sd;
      if (op == 6) begin
        rq.be    = 4'b0001 << a[1:0];
        rq.wdata = {24'd0, sb} * 32'h0101_0101;
      end else if (op == 7) begin
        rq.be    = a[1] ? 4'b1100 : 4'b0011;
        rq.wdata = {16'd0, sh} * 32'h0001_0001;
      end
      req_q.push_back(rq);
    end
    we.rd  = r;
    we.exc = mis;
    if (!(ld || st) || mis) begin
      we.rw = w && !mis;
      we.data = a;
      we.chk_data = 1'b1;
      we.cyc = acc_cyc + 1;
    end else if (st) begin
      we.rw = 1'b0;
      we.data = 32'd0;
      we.chk_data = 1'b0;
      we.cyc = acc_cyc + 2 + hold;
    end else begin
      we.rw = w;
      we.data = load_model(op, a, rdata);
      we.chk_data = 1'b1;
      we.cyc = acc_cyc + 2 + hold + rv_delay;
    end
    wb_q.push_back(we);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Memory responder: checks each request against the queued expectation and plays gnt/rvalid timing.
  bit          active = 0;
  req_exp_t    cur;
  int          hold_cnt = 0;
  bit          rv_pend = 0;
  int          rv_cnt = 0;
  logic [31:0] rv_data;

  initial begin
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'd0;
  end

  always @(negedge clk) begin
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = $urandom;
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rv_data;
        rv_pend = 0;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      dmem_bus.dmem_rvalid = 1'b1;
    end
    if (dmem_bus.dmem_req === 1'b1) begin
      if (!active) begin
        if (req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: dmem_req=1 with addr %h, required no request", dmem_bus.dmem_addr);
          dmem_bus.dmem_gnt = 1'b1;
        end else begin
          cur = req_q.pop_front();
          active = 1;
          hold_cnt = cur.hold;
        end
      end
      if (active) begin
        chk("req_we", {31'd0, dmem_bus.dmem_we}, {31'd0, cur.we});
        chk("req_addr", dmem_bus.dmem_addr, cur.addr);
        if (cur.we) begin
          chk("req_be", {28'd0, dmem_bus.dmem_be}, {28'd0, cur.be});
          chk("req_wdata", dmem_bus.dmem_wdata, cur.wdata);
        end
        if (hold_cnt == 0) begin
          dmem_bus.dmem_gnt = 1'b1;
          active = 0;
          if (!cur.we) begin
            rv_pend = 1;
            rv_cnt  = cur.rv_delay;
            rv_data = cur.rdata;
          end
        end else begin
          hold_cnt--;
        end
      end
    end else begin
      active = 0;
      if ($urandom_range(0, 7) == 0) dmem_bus.dmem_gnt = 1'b1;
    end
  end

  // Writeback monitor
  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_valid === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d data=%h, required no writeback", wb_rd, wb_data);
      end else begin
        e = wb_q.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
        chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, e.exc});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, g;
    int op;
    in_valid = 1'b0; alu_res = 32'd0; store_data = 32'd0;
    mem_op = 4'd0; rd = 5'd0; reg_write = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dmem_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_bus.dmem_be}, 32'd0);
    chk("rst_dmem_addr", dmem_bus.dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_bus.dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misalign_exc", {31'd0, misalign_exc}, 32'd0);
    rst = 1'b0;

    issue(0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 32'd0, 0, 1, a0);
    issue(6, 32'h0000_1003, 32'haabb_ccdd, 5'd9, 1'b1, 32'd0, 2, 1, a0);
    issue(1, 32'h0000_2002, 32'd0, 5'd1, 1'b1, 32'h80ff_7f01, 0, 1, a0);
    issue(2, 32'h0000_2002, 32'd0, 5'd2, 1'b1, 32'h80ff_7f01, 1, 2, a0);
    issue(3, 32'h0000_2002, 32'd0, 5'd3, 1'b1, 32'h80ff_7f01, 0, 1, a0);
    issue(1, 32'h0000_2003, 32'd0, 5'd4, 1'b1, 32'h80ff_7f01, 0, 1, a0);
    issue(7, 32'h0000_3002, 32'h1122_3344, 5'd6, 1'b0, 32'd0, 0, 1, a0);
    issue(8, 32'h0000_3004, 32'hcafe_f00d, 5'd7, 1'b0, 32'd0, 1, 1, a0);
    issue(5, 32'h0000_4000, 32'd0, 5'd8, 1'b1, 32'hdead_beef, 0, 4, a0);
    issue(0, 32'h0000_0abc, 32'd0, 5'd10, 1'b1, 32'd0, 0, 1, a1);
    chk("b2b_accept_cycle", a1, a0 + 6);
    issue(5, 32'h0000_0006, 32'd0, 5'd11, 1'b1, 32'h0bad_f00d, 0, 1, a0);
    issue(12, 32'h5555_aaaa, 32'd0, 5'd12, 1'b1, 32'd0, 0, 1, a0);

    // Reset while waiting for load data; the late rvalid must be dropped.
    issue(5, 32'h0000_5000, 32'd0, 5'd13, 1'b1, 32'h1357_9bdf, 0, 8, a0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_dmem_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (12) @(negedge clk);
    issue(0, 32'h7777_0000, 32'd0, 5'd14, 1'b1, 32'd0, 0, 1, a0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      issue(op, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 2), $urandom_range(1, 4), a0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    g = 0;
    while (wb_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("req_queue_drained", req_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
